// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM fader: channel count, pin polarity, level type.
package led_pkg;
    localparam int NUM_LEDS = 6;
    localparam int CLK_HZ   = 27_000_000;
    localparam int PWM_BITS = 8;

    localparam logic LED_OFF = 1'b1;
    localparam logic LED_ON  = 1'b0;

    typedef logic [PWM_BITS-1:0] level_t;
endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating brightness ramp, period-aligned shadow duty, PWM compare.
// Output is registered; duty only reloads on the period wrap so a period is never cut short.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                lit_target,
    input  logic                fade_tick,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                fade_en,
    output logic                led,
    output logic                at_target
);
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, MAX};
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(FADE_STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   up_sum, dn_diff;
    logic                led_q, led_d;
    logic                pwm_lit;

    always_comb begin
        target  = lit_target ? MAX : '0;
        up_sum  = {1'b0, level_q} + STEP_W;
        dn_diff = {1'b0, level_q} - STEP_W;

        level_d = level_q;
        if (!fade_en) begin
            level_d = target;
        end else if (fade_tick) begin
            // The extra bit catches overshoot past MAX and the borrow below 0.
            if (lit_target) begin
                level_d = (up_sum > MAX_W) ? MAX : up_sum[PWM_BITS-1:0];
            end else begin
                level_d = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
            end
        end

        duty_d = duty_q;
        if (!fade_en) begin
            duty_d = target;
        end else if (wrap) begin
            duty_d = level_q;
        end

        pwm_lit = (duty_q == MAX) || (pwm_cnt < duty_q);
        if (fade_en) begin
            led_d = pwm_lit ? LED_ON : LED_OFF;
        end else begin
            led_d = lit_target ? LED_ON : LED_OFF;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            level_q <= '0;
            duty_q  <= '0;
            led_q   <= LED_OFF;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
        end
    end

    assign led       = led_q;
    assign at_target = (level_q == target);
endmodule

// File: rtl/led_pwm_fader.sv
// Per-LED PWM fader behind the shifting pattern generator; bypass passes the pattern through.
// Latency pattern_in->led_out is 2 cycles in bypass; no backpressure, runs every sys_clk.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int NUM_LEDS         = led_pkg::NUM_LEDS,
    parameter int PWM_BITS         = led_pkg::PWM_BITS,
    parameter int PWM_DIV          = 4,
    parameter int FADE_TICK_CYCLES = 27000,
    parameter int FADE_STEP        = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                fade_en,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                settled
);
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int FT_W  = (FADE_TICK_CYCLES > 1) ? $clog2(FADE_TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [FT_W-1:0]     FT_LAST  = FT_W'(FADE_TICK_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [PRE_W-1:0]    pwm_pre_q, pwm_pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FT_W-1:0]     fade_cnt_q, fade_cnt_d;
    logic                settled_q, settled_d;

    logic                pre_last;
    logic                fade_tick;
    logic                wrap;
    logic [NUM_LEDS-1:0] led_bits;
    logic [NUM_LEDS-1:0] at_target;

    always_comb begin
        pre_last   = (pwm_pre_q == PRE_LAST);
        fade_tick  = (fade_cnt_q == FT_LAST);
        wrap       = pre_last && (pwm_cnt_q == PWM_MAX);

        pwm_pre_d  = pre_last ? '0 : pwm_pre_q + PRE_W'(1);
        // pwm_cnt wraps MAX->0 through natural overflow.
        pwm_cnt_d  = pre_last ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        fade_cnt_d = fade_tick ? '0 : fade_cnt_q + FT_W'(1);

        pattern_d  = pattern_in;
        settled_d  = &at_target;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pattern_q  <= '1;
            pwm_pre_q  <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            settled_q  <= 1'b1;
        end else begin
            pattern_q  <= pattern_d;
            pwm_pre_q  <= pwm_pre_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            settled_q  <= settled_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .lit_target (pattern_q[i] == LED_ON),
            .fade_tick  (fade_tick),
            .wrap       (wrap),
            .pwm_cnt    (pwm_cnt_q),
            .fade_en    (fade_en),
            .led        (led_bits[i]),
            .at_target  (at_target[i])
        );
    end

    assign led_out = led_bits;
    assign settled = settled_q;
endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: directed ramp/bypass/reset cases plus random patterns against a cycle-count model.
module tb_led_pwm_fader;
    localparam int NL     = 6;
    localparam int DIV    = 1;
    localparam int FTC    = 8;
    localparam int STEP   = 64;
    localparam int MAXV   = 255;
    localparam int PERIOD = 256 * DIV;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [NL-1:0] pattern_in;
    logic          fade_en;
    logic [NL-1:0] led_out;
    logic          settled;
    logic [7:0]    lvl0;

    led_pwm_fader #(
        .NUM_LEDS         (NL),
        .PWM_BITS         (8),
        .PWM_DIV          (DIV),
        .FADE_TICK_CYCLES (FTC),
        .FADE_STEP        (STEP)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pattern_in (pattern_in),
        .fade_en    (fade_en),
        .led_out    (led_out),
        .settled    (settled)
    );

    assign lvl0 = dut.g_ch[0].u_ch.level_q;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: counters are pure functions of cycles since reset.
    int            m_level[NL];
    int            m_duty[NL];
    logic [NL-1:0] m_pat     = '1;
    logic [NL-1:0] m_led     = '1;
    logic          m_settled = 1'b1;
    int            m_cyc     = 0;
    int            m_byp_cnt = 0;

    always @(posedge sys_clk) begin : model
        int            pcnt, tgt;
        int            nl[NL];
        int            nd[NL];
        bit            tick, wrap, all_ok;
        logic [NL-1:0] nled;
        if (!sys_rst_n) begin
            for (int i = 0; i < NL; i++) begin
                m_level[i] = 0;
                m_duty[i]  = 0;
            end
            m_pat = '1; m_led = '1; m_settled = 1'b1; m_cyc = 0;
        end else begin
            tick   = (m_cyc % FTC) == FTC - 1;
            wrap   = (m_cyc % PERIOD) == PERIOD - 1;
            pcnt   = (m_cyc / DIV) % 256;
            all_ok = 1;
            for (int i = 0; i < NL; i++) begin
                tgt = m_pat[i] ? 0 : MAXV;
                if (m_level[i] != tgt) all_ok = 0;
                nled[i] = fade_en ? !(m_duty[i] == MAXV || pcnt < m_duty[i]) : m_pat[i];
                nd[i]   = !fade_en ? tgt : (wrap ? m_level[i] : m_duty[i]);
                if (!fade_en)       nl[i] = tgt;
                else if (!tick)     nl[i] = m_level[i];
                else if (!m_pat[i]) nl[i] = (m_level[i] + STEP > MAXV) ? MAXV : m_level[i] + STEP;
                else                nl[i] = (m_level[i] - STEP < 0) ? 0 : m_level[i] - STEP;
            end
            for (int i = 0; i < NL; i++) begin
                m_level[i] = nl[i];
                m_duty[i]  = nd[i];
            end
            m_led     = nled;
            m_settled = all_ok;
            m_pat     = pattern_in;
            m_cyc++;
            if (!fade_en) m_byp_cnt++;
        end
    end

    // Every cycle check pins and level; every full PWM period check low-cycle count of LED 0.
    bit chk_on   = 0;
    int low_cnt  = 0;
    int per_duty = 0;
    int byp_snap = 0;

    always @(negedge sys_clk) begin
        if (chk_on) begin
            check("led_out", int'(led_out), int'(m_led));
            check("settled", int'(settled), int'(m_settled));
            check("level0", int'(lvl0), m_level[0]);
            if (m_cyc == 0) begin
                low_cnt  = 0;
                per_duty = 0;
                byp_snap = m_byp_cnt;
            end else begin
                if (!led_out[0]) low_cnt++;
                if (m_cyc % PERIOD == 0) begin
                    if (byp_snap == m_byp_cnt)
                        check("period_low", low_cnt, (per_duty == MAXV ? 256 : per_duty) * DIV);
                    low_cnt  = 0;
                    per_duty = m_duty[0];
                    byp_snap = m_byp_cnt;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        bit found;
        sys_rst_n  = 1'b0;
        pattern_in = '0;
        fade_en    = 1'b1;
        step(3);
        check("rst_led", int'(led_out), 'h3F);
        check("rst_settled", int'(settled), 1);
        check("rst_level0", int'(lvl0), 0);
        chk_on = 1;

        // Ramp channel 0 up to saturation, then back down to 0.
        pattern_in = 6'b111110;
        sys_rst_n  = 1'b1;
        step(600);
        check("up_level0", int'(lvl0), 255);
        check("up_led", int'(led_out), 'h3E);
        check("up_settled", int'(settled), 1);
        pattern_in = 6'b111111;
        step(600);
        check("down_level0", int'(lvl0), 0);
        check("down_led", int'(led_out), 'h3F);

        // Random patterns with occasional bypass segments.
        for (int k = 0; k < 70; k++) begin
            pattern_in = 6'($urandom);
            fade_en    = ($urandom_range(15) != 0);
            step($urandom_range(80, 1));
        end

        // Bypass: pattern sampled at edge N shows on the pins at edge N+2.
        fade_en    = 1'b0;
        pattern_in = 6'b101010;
        step(3);
        check("byp_led", int'(led_out), 'h2A);
        check("byp_settled", int'(settled), 1);

        // Sync reset mid-ramp, preceded by a glitch that no edge samples.
        pattern_in = 6'b111111;
        step(3);
        fade_en    = 1'b1;
        pattern_in = 6'b111110;
        found = 0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge sys_clk);
            if (lvl0 == 8'd128) found = 1;
        end
        check("wait_level128", int'(found), 1);
        #2 sys_rst_n = 1'b0;
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("glitch_level0", int'(lvl0), 128);
        sys_rst_n = 1'b0;
        step(1);
        check("mrst_led", int'(led_out), 'h3F);
        check("mrst_level0", int'(lvl0), 0);
        check("mrst_settled", int'(settled), 1);
        sys_rst_n = 1'b1;
        step(600);
        check("post_rst_level0", int'(lvl0), 255);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
